// File: rtl/range_zone_monitor_pkg.sv
// rtl/range_zone_monitor_pkg.sv - shared types and default constants for the range zone monitor.
package range_zone_monitor_pkg;

  localparam int unsigned DEF_CYC_PER_CM = 2900;
  localparam int unsigned DEF_MAX_CM     = 400;
  localparam int unsigned COUNT_W        = 23;
  localparam int unsigned CM_W           = 9;
  localparam int unsigned SUM_W          = 11;

  typedef enum logic [1:0] {
    ZONE_CLEAR = 2'd0,
    ZONE_WARN  = 2'd1,
    ZONE_NEAR  = 2'd2
  } zone_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIVIDE,
    ST_FILTER,
    ST_CLASSIFY
  } state_e;

endpackage

// File: rtl/range_zone_monitor_divider.sv
// rtl/range_zone_monitor_divider.sv - serial restoring divider by a constant, one quotient bit per cycle.
module range_divider
  import range_zone_monitor_pkg::*;
#(
  parameter int unsigned DIVISOR = DEF_CYC_PER_CM
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [COUNT_W-1:0] dividend_i,
  output logic               done_o,
  output logic [COUNT_W-1:0] quotient_o
);

  localparam int unsigned   RW    = COUNT_W + 1;
  localparam logic [RW-1:0] DIV_L = RW'(DIVISOR);
  localparam logic [4:0]    LAST  = 5'(COUNT_W - 1);

  logic [COUNT_W-1:0] rem_q, rem_d;
  logic [COUNT_W-1:0] quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [RW-1:0]      trial;
  logic               ge;

  // quo_q starts as the dividend and is shifted out MSB-first while quotient bits shift in
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    trial  = {rem_q, quo_q[COUNT_W-1]};
    ge     = (trial >= DIV_L);
    if (start_i) begin
      rem_d  = '0;
      quo_d  = dividend_i;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = COUNT_W'(ge ? trial - DIV_L : trial);
      quo_d = {quo_q[COUNT_W-2:0], ge};
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == LAST) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done_o     = busy_q && (cnt_q == LAST);
  assign quotient_o = quo_q;

endmodule

// File: rtl/range_zone_monitor.sv
// rtl/range_zone_monitor.sv - echo count to cm, 4-tap average, zone hysteresis, buzzer and stop.
module range_zone_monitor
  import range_zone_monitor_pkg::*;
#(
  parameter int unsigned CYC_PER_CM = DEF_CYC_PER_CM,
  parameter int unsigned MAX_CM     = DEF_MAX_CM,
  parameter int unsigned NEAR_CM    = 20,
  parameter int unsigned WARN_CM    = 60,
  parameter int unsigned HYST_CM    = 5,
  parameter int unsigned BEEP_HALF  = 6_250_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COUNT_W-1:0] dist_count,
  input  logic               dist_valid,
  output logic [CM_W-1:0]    dist_cm,
  output logic               cm_valid,
  output logic [1:0]         zone,
  output logic               stop,
  output logic               buzz,
  output logic               no_echo,
  output logic               overrun
);

  localparam int unsigned     BW      = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
  localparam logic [BW-1:0]   BEEP_LAST = BW'(BEEP_HALF - 1);
  localparam logic [CM_W-1:0] MAX_L   = CM_W'(MAX_CM);
  localparam logic [CM_W-1:0] NEAR_L  = CM_W'(NEAR_CM);
  localparam logic [CM_W-1:0] WARN_L  = CM_W'(WARN_CM);
  localparam logic [CM_W-1:0] NEAR_X  = CM_W'(NEAR_CM + HYST_CM);
  localparam logic [CM_W-1:0] WARN_X  = CM_W'(WARN_CM + HYST_CM);

  state_e                 state_q, state_d;
  logic [3:0][CM_W-1:0]   taps_q, taps_d;
  logic                   taps_full_q, taps_full_d;
  logic [CM_W-1:0]        dist_cm_q, dist_cm_d;
  zone_e                  zone_q, zone_d;
  logic                   cm_valid_q, cm_valid_d;
  logic                   buzz_q, buzz_d;
  logic [BW-1:0]          beep_cnt_q, beep_cnt_d;
  logic                   no_echo_q, no_echo_d;
  logic                   overrun_q, overrun_d;

  logic                   accept;
  logic                   div_done;
  logic [COUNT_W-1:0]     quotient;
  logic [CM_W-1:0]        sample;
  logic [SUM_W-1:0]       sum;
  logic [CM_W-1:0]        avg;
  zone_e                  zone_next;

  assign accept = (state_q == ST_IDLE) && dist_valid;

  range_divider #(
    .DIVISOR(CYC_PER_CM)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start_i   (accept),
    .dividend_i(dist_count),
    .done_o    (div_done),
    .quotient_o(quotient)
  );

  // A zero count means no echo came back, which reads as "nothing in range"
  assign sample = (no_echo_q || quotient >= COUNT_W'(MAX_CM)) ? MAX_L : quotient[CM_W-1:0];
  assign sum    = SUM_W'(taps_q[0]) + SUM_W'(taps_q[1]) + SUM_W'(taps_q[2]) + SUM_W'(taps_q[3]);
  assign avg    = CM_W'(sum >> 2);

  always_comb begin
    zone_next = zone_q;
    case (zone_q)
      ZONE_CLEAR: begin
        if (avg < NEAR_L)      zone_next = ZONE_NEAR;
        else if (avg < WARN_L) zone_next = ZONE_WARN;
      end
      ZONE_WARN: begin
        if (avg < NEAR_L)       zone_next = ZONE_NEAR;
        else if (avg >= WARN_X) zone_next = ZONE_CLEAR;
      end
      ZONE_NEAR: begin
        if (avg >= WARN_X)      zone_next = ZONE_CLEAR;
        else if (avg >= NEAR_X) zone_next = ZONE_WARN;
      end
      default: zone_next = ZONE_CLEAR;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (dist_valid) state_d = ST_DIVIDE;
      ST_DIVIDE:   if (div_done) state_d = ST_FILTER;
      ST_FILTER:   state_d = ST_CLASSIFY;
      ST_CLASSIFY: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    taps_d      = taps_q;
    taps_full_d = taps_full_q;
    dist_cm_d   = dist_cm_q;
    zone_d      = zone_q;
    cm_valid_d  = 1'b0;
    buzz_d      = buzz_q;
    beep_cnt_d  = beep_cnt_q;
    no_echo_d   = no_echo_q;
    overrun_d   = overrun_q;

    if (accept) no_echo_d = (dist_count == '0);
    if (dist_valid && state_q != ST_IDLE) overrun_d = 1'b1;

    if (zone_q == ZONE_WARN) begin
      if (beep_cnt_q == BEEP_LAST) begin
        beep_cnt_d = '0;
        buzz_d     = ~buzz_q;
      end else begin
        beep_cnt_d = beep_cnt_q + BW'(1);
      end
    end

    if (state_q == ST_FILTER) begin
      taps_full_d = 1'b1;
      if (!taps_full_q) taps_d = {4{sample}};
      else              taps_d = {taps_q[2:0], sample};
    end

    // Zone update overrides the free-running beep step; WARN entry restarts the cadence high
    if (state_q == ST_CLASSIFY) begin
      dist_cm_d  = avg;
      cm_valid_d = 1'b1;
      zone_d     = zone_next;
      case (zone_next)
        ZONE_NEAR: buzz_d = 1'b1;
        ZONE_WARN: begin
          if (zone_q != ZONE_WARN) begin
            buzz_d     = 1'b1;
            beep_cnt_d = '0;
          end
        end
        default: begin
          buzz_d     = 1'b0;
          beep_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      taps_q      <= '0;
      taps_full_q <= 1'b0;
      dist_cm_q   <= MAX_L;
      zone_q      <= ZONE_CLEAR;
      cm_valid_q  <= 1'b0;
      buzz_q      <= 1'b0;
      beep_cnt_q  <= '0;
      no_echo_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      taps_q      <= taps_d;
      taps_full_q <= taps_full_d;
      dist_cm_q   <= dist_cm_d;
      zone_q      <= zone_d;
      cm_valid_q  <= cm_valid_d;
      buzz_q      <= buzz_d;
      beep_cnt_q  <= beep_cnt_d;
      no_echo_q   <= no_echo_d;
      overrun_q   <= overrun_d;
    end
  end

  assign dist_cm  = dist_cm_q;
  assign cm_valid = cm_valid_q;
  assign zone     = zone_q;
  assign stop     = (zone_q == ZONE_NEAR);
  assign buzz     = buzz_q;
  assign no_echo  = no_echo_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_range_zone_monitor.sv
// tb/tb_range_zone_monitor.sv - scoreboard bench for range_zone_monitor with directed frames.
module tb_range_zone_monitor;

  localparam int BEEP = 16;
  localparam int LAT  = 26;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [22:0] dist_count = '0;
  logic        dist_valid = 1'b0;
  logic [8:0]  dist_cm;
  logic        cm_valid;
  logic [1:0]  zone;
  logic        stop;
  logic        buzz;
  logic        no_echo;
  logic        overrun;

  range_zone_monitor #(
    .CYC_PER_CM(2900),
    .MAX_CM    (400),
    .NEAR_CM   (20),
    .WARN_CM   (60),
    .HYST_CM   (5),
    .BEEP_HALF (BEEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dist_count(dist_count),
    .dist_valid(dist_valid),
    .dist_cm   (dist_cm),
    .cm_valid  (cm_valid),
    .zone      (zone),
    .stop      (stop),
    .buzz      (buzz),
    .no_echo   (no_echo),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cm;
    int zn;
    int ne;
    int bz;   // 2 = phase-dependent, not checked
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && cm_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_cm_valid: got dist_cm=%0d, expected no output", dist_cm);
      end else begin
        e = sb.pop_front();
        chk("dist_cm", int'(dist_cm), e.cm);
        chk("zone", int'(zone), e.zn);
        chk("stop", int'(stop), (e.zn == 2) ? 1 : 0);
        chk("no_echo", int'(no_echo), e.ne);
        if (e.bz != 2) chk("buzz", int'(buzz), e.bz);
        chk("latency", cyc - e.cyc, LAT);
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_dist_cm"}, int'(dist_cm), 400);
    chk({tag, "_zone"}, int'(zone), 0);
    chk({tag, "_stop"}, int'(stop), 0);
    chk({tag, "_buzz"}, int'(buzz), 0);
    chk({tag, "_cm_valid"}, int'(cm_valid), 0);
    chk({tag, "_no_echo"}, int'(no_echo), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask

  task automatic send(input int cnt, input int cm, input int zn, input int ne, input int bz,
                      input int gap);
    exp_t x;
    x.cm = cm; x.zn = zn; x.ne = ne; x.bz = bz; x.cyc = cyc;
    sb.push_back(x);
    dist_count = 23'(cnt);
    dist_valid = 1'b1;
    @(negedge clk);
    dist_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse(input int cnt);
    dist_count = 23'(cnt);
    dist_valid = 1'b1;
    @(negedge clk);
    dist_valid = 1'b0;
  endtask

  task automatic beep_check();
    int found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (cm_valid) found = 1;
    end
    chk("warn_entry_seen", found, 1);
    if (found == 1) begin
      chk("beep_k0", int'(buzz), 1);
      repeat (BEEP - 1) @(negedge clk);
      chk("beep_k15", int'(buzz), 1);
      @(negedge clk);
      chk("beep_k16", int'(buzz), 0);
      repeat (BEEP - 1) @(negedge clk);
      chk("beep_k31", int'(buzz), 0);
      @(negedge clk);
      chk("beep_k32", int'(buzz), 1);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset("rst0");

    send(29000, 10, 2, 0, 1, 28);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("rst1");

    send(0, 400, 0, 1, 0, 28);
    send(2_000_000, 400, 0, 0, 0, 28);

    send(159500, 313, 0, 0, 0, 28);
    send(159500, 227, 0, 0, 0, 28);
    send(159500, 141, 0, 0, 0, 28);
    send(159500, 55, 1, 0, 1, 0);
    beep_check();
    repeat (3) @(negedge clk);

    send(179800, 56, 1, 0, 2, 28);
    send(179800, 58, 1, 0, 2, 28);
    send(179800, 60, 1, 0, 2, 28);
    send(179800, 62, 1, 0, 2, 28);

    send(191400, 63, 1, 0, 2, 28);
    send(191400, 64, 1, 0, 2, 28);
    send(191400, 65, 0, 0, 0, 28);
    send(191400, 66, 0, 0, 0, 28);

    send(116000, 59, 1, 0, 1, 28);
    send(116000, 53, 1, 0, 2, 28);
    send(116000, 46, 1, 0, 2, 28);
    send(116000, 40, 1, 0, 2, 28);
    send(232000, 50, 1, 0, 2, 28);

    send(29000, 42, 1, 0, 2, 4);
    pulse(232000);
    repeat (30) @(negedge clk);
    chk("overrun_sticky", int'(overrun), 1);

    pulse(116000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_mid");
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check_reset("after_abort");

    send(57999, 19, 2, 0, 1, 28);
    send(58000, 19, 2, 0, 1, 28);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

endmodule
